// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I-subset control FSM:
// opcodes, state encodings, ALU control constants and per-state output decode.
package multicycle_pkg;

   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] RTYPE = 7'b0110011;
   localparam logic [6:0] ITYPE = 7'b0010011;
   localparam logic [6:0] BEQ   = 7'b1100011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_ACC  = 4'd3,
      LOAD_WB  = 4'd4,
      EXEC_R   = 4'd5,
      EXEC_I   = 4'd6,
      ALU_WB   = 4'd7,
      BRANCH   = 4'd8,
      TRAP     = 4'd9
   } state_t;

   // Registered per-state controls; in_fetch/in_branch feed the two
   // outputs that are qualified by live inputs (mem_ready, zero).
   typedef struct packed {
      logic       mem_req;
      logic       mem_wr;
      logic       i_or_d;
      logic       reg_wr;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
      logic       in_fetch;
      logic       in_branch;
   } ctrl_t;

   function automatic ctrl_t ctrl_decode(state_t s, logic store);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_req   = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_ADD;
            c.in_fetch  = 1'b1;
         end
         DECODE: c.alu_src_b = SRCB_IMM;
         MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         MEM_ACC: begin
            c.mem_req = 1'b1;
            c.i_or_d  = 1'b1;
            c.mem_wr  = store;
         end
         LOAD_WB: begin
            c.reg_wr     = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALU_FUNCT;
         end
         EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_FUNCT;
         end
         ALU_WB: c.reg_wr = 1'b1;
         BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALU_SUB;
            c.in_branch = 1'b1;
         end
         TRAP: c.illegal = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_opdec.sv
// Combinational opcode classifier for the multicycle control FSM.
module mc_opdec
   import multicycle_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic       is_mem,
   output logic       is_store,
   output logic       is_r,
   output logic       is_i,
   output logic       is_br,
   output logic       is_bad
);

   // Classify the IR opcode; anything unrecognised is trapped.
   always_comb begin
      is_store = (opcode_i == STORE);
      is_mem   = (opcode_i == LOAD) || is_store;
      is_r     = (opcode_i == RTYPE);
      is_i     = (opcode_i == ITYPE);
      is_br    = (opcode_i == BEQ);
      is_bad   = !(is_mem || is_r || is_i || is_br);
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32I-subset datapath with one shared
// memory port. Optional perf counters under MULTICYCLE_CONTROL_PERF_EN.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int OPC_W = 7,
   parameter int ST_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_wr,
   output logic             pc_src,
   output logic             ir_wr,
   output logic             mem_req,
   output logic             mem_wr,
   output logic             i_or_d,
   output logic             reg_wr,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             illegal,
   output logic [ST_W-1:0]  state_o
`ifdef MULTICYCLE_CONTROL_PERF_EN
   ,
   output logic [31:0]      cycle_cnt,
   output logic [31:0]      instret_cnt
`endif
);

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   is_mem, is_store, is_r, is_i, is_br, is_bad;

   mc_opdec u_opdec (
      .opcode_i (opcode[6:0]),
      .is_mem   (is_mem),
      .is_store (is_store),
      .is_r     (is_r),
      .is_i     (is_i),
      .is_br    (is_br),
      .is_bad   (is_bad)
   );

   // Next-state logic; controls are precomputed for the next state so they
   // leave the flops cleanly at the start of each state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            if (is_bad)      state_d = TRAP;
            else if (is_mem) state_d = MEM_ADDR;
            else if (is_r)   state_d = EXEC_R;
            else if (is_i)   state_d = EXEC_I;
            else if (is_br)  state_d = BRANCH;
            else             state_d = TRAP;
         end
         MEM_ADDR: state_d = MEM_ACC;
         MEM_ACC:  if (mem_ready) state_d = is_store ? FETCH : LOAD_WB;
         LOAD_WB:  state_d = FETCH;
         EXEC_R:   state_d = ALU_WB;
         EXEC_I:   state_d = ALU_WB;
         ALU_WB:   state_d = FETCH;
         BRANCH:   state_d = FETCH;
         TRAP:     state_d = TRAP;
         default:  state_d = FETCH;
      endcase
      ctrl_d = ctrl_decode(state_d, is_store);
   end

   // State and registered controls; reset lands in FETCH with its controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         ctrl_q  <= ctrl_decode(FETCH, 1'b0);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Everything is forced low while reset is held; only the FETCH load enables
   // and the BRANCH pc_wr look at live inputs.
   assign mem_req    = ctrl_q.mem_req    & ~rst;
   assign mem_wr     = ctrl_q.mem_wr     & ~rst;
   assign i_or_d     = ctrl_q.i_or_d     & ~rst;
   assign reg_wr     = ctrl_q.reg_wr     & ~rst;
   assign mem_to_reg = ctrl_q.mem_to_reg & ~rst;
   assign alu_src_a  = ctrl_q.alu_src_a  & ~rst;
   assign alu_src_b  = ctrl_q.alu_src_b  & {2{~rst}};
   assign alu_op     = ctrl_q.alu_op     & {2{~rst}};
   assign illegal    = ctrl_q.illegal    & ~rst;
   assign ir_wr      = ctrl_q.in_fetch & mem_ready & ~rst;
   assign pc_src     = ctrl_q.in_branch & ~rst;
   assign pc_wr      = ((ctrl_q.in_fetch & mem_ready) | (ctrl_q.in_branch & zero)) & ~rst;
   assign state_o    = ST_W'(state_q);

`ifdef MULTICYCLE_CONTROL_PERF_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] instret_cnt_q, instret_cnt_d;
   logic        retire;

   // An instruction retires when a completing state hands back to FETCH.
   always_comb begin
      retire = (state_d == FETCH) &&
               ((state_q == LOAD_WB) || (state_q == ALU_WB) ||
                (state_q == BRANCH)  || (state_q == MEM_ACC));
      cycle_cnt_d   = cycle_cnt_q + 32'd1;
      instret_cnt_d = instret_cnt_q + (retire ? 32'd1 : 32'd0);
   end

   // Free-running perf counters, wrapping naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes the expected
// output vector for each cycle, the monitor pops and compares after inputs settle.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_wr, pc_src, ir_wr, mem_req, mem_wr, i_or_d, reg_wr, mem_to_reg;
   logic       alu_src_a, illegal;
   logic [1:0] alu_src_b, alu_op;
   logic [3:0] state_o;
`ifdef MULTICYCLE_CONTROL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   multicycle_control #(.OPC_W(7), .ST_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_wr      (pc_wr),
      .pc_src     (pc_src),
      .ir_wr      (ir_wr),
      .mem_req    (mem_req),
      .mem_wr     (mem_wr),
      .i_or_d     (i_or_d),
      .reg_wr     (reg_wr),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .illegal    (illegal),
      .state_o    (state_o)
`ifdef MULTICYCLE_CONTROL_PERF_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .instret_cnt(instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [17:0] v;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [17:0] dut_vec();
      return {state_o, pc_wr, pc_src, ir_wr, mem_req, mem_wr, i_or_d, reg_wr,
              mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};
   endfunction

   // Hand table of the control outputs for each state.
   function automatic logic [17:0] ev(logic r, logic rdy, logic z, logic [6:0] opc, logic [3:0] st);
      logic pw, ps, iw, mr, mw, id, rw, m2r, a, ill;
      logic [1:0] b, op;
      {pw, ps, iw, mr, mw, id, rw, m2r, a, ill} = '0;
      b = 2'b00; op = 2'b00;
      if (r) return 18'd0;
      case (st)
         4'd0: begin mr = 1; b = 2'b01; pw = rdy; iw = rdy; end
         4'd1: b = 2'b10;
         4'd2: begin a = 1; b = 2'b10; end
         4'd3: begin mr = 1; id = 1; mw = (opc == OP_ST); end
         4'd4: begin rw = 1; m2r = 1; end
         4'd5: begin a = 1; b = 2'b00; op = 2'b10; end
         4'd6: begin a = 1; b = 2'b10; op = 2'b10; end
         4'd7: rw = 1;
         4'd8: begin a = 1; op = 2'b01; ps = 1; pw = z; end
         4'd9: ill = 1;
         default: ;
      endcase
      return {st, pw, ps, iw, mr, mw, id, rw, m2r, a, b, op, ill};
   endfunction

   task automatic chk(input string tag, input logic [17:0] act, input logic [17:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h", tag, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue its expectation.
   task automatic cyc(input logic r, input logic rdy, input logic z,
                      input logic [6:0] opc, input logic [3:0] st, input string tag);
      exp_t e;
      @(negedge clk);
      rst = r; mem_ready = rdy; zero = z; opcode = opc;
      e.tag = tag;
      e.v   = ev(r, rdy, z, opc, st);
      q.push_back(e);
   endtask

   // Monitor: compare whatever the DUT presents once the inputs have settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.tag, dut_vec(), e.v);
         end
      end
   end

   initial begin
      // reset held
      cyc(1, 1, 0, OP_R, 0, "reset0");
      cyc(1, 1, 0, OP_R, 0, "reset1");
      // zero-wait R-type
      cyc(0, 1, 0, OP_R, 0, "r_fetch");
      cyc(0, 1, 0, OP_R, 1, "r_decode");
      cyc(0, 1, 0, OP_R, 5, "r_exec");
      cyc(0, 1, 0, OP_R, 7, "r_wb");
      // fetch stall then I-type; mem_ready low in DECODE is ignored
      cyc(0, 0, 0, OP_I, 0, "i_fetch_wait");
      cyc(0, 1, 0, OP_I, 0, "i_fetch");
      cyc(0, 0, 0, OP_I, 1, "i_decode");
      cyc(0, 0, 0, OP_I, 6, "i_exec");
      cyc(0, 0, 0, OP_I, 7, "i_wb");
      // load with two wait cycles at MEM_ACC
      cyc(0, 1, 0, OP_LD, 0, "ld_fetch");
      cyc(0, 1, 0, OP_LD, 1, "ld_decode");
      cyc(0, 1, 0, OP_LD, 2, "ld_addr");
      cyc(0, 0, 0, OP_LD, 3, "ld_acc_w0");
      cyc(0, 0, 0, OP_LD, 3, "ld_acc_w1");
      cyc(0, 1, 0, OP_LD, 3, "ld_acc_rdy");
      cyc(0, 1, 0, OP_LD, 4, "ld_wb");
      // store, zero wait
      cyc(0, 1, 0, OP_ST, 0, "st_fetch");
      cyc(0, 1, 0, OP_ST, 1, "st_decode");
      cyc(0, 1, 0, OP_ST, 2, "st_addr");
      cyc(0, 1, 0, OP_ST, 3, "st_acc");
      // branch taken then not taken
      cyc(0, 1, 0, OP_BR, 0, "br1_fetch");
      cyc(0, 1, 0, OP_BR, 1, "br1_decode");
      cyc(0, 1, 1, OP_BR, 8, "br1_taken");
      cyc(0, 1, 0, OP_BR, 0, "br0_fetch");
      cyc(0, 1, 1, OP_BR, 1, "br0_decode");
      cyc(0, 1, 0, OP_BR, 8, "br0_not_taken");
      // illegal opcode traps until reset
      cyc(0, 1, 0, OP_BAD, 0, "bad_fetch");
      cyc(0, 1, 0, OP_BAD, 1, "bad_decode");
      for (int i = 0; i < 20; i++) cyc(0, i[0], i[1], OP_BAD, 9, "trap_hold");
      cyc(1, 1, 0, OP_R, 0, "trap_rst");
      cyc(0, 0, 0, OP_R, 0, "trap_exit");
      // async reset pulse between edges mid MEM_ACC
      cyc(0, 1, 0, OP_LD, 0, "ar_fetch");
      cyc(0, 1, 0, OP_LD, 1, "ar_decode");
      cyc(0, 1, 0, OP_LD, 2, "ar_addr");
      cyc(0, 0, 0, OP_LD, 3, "ar_acc");
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("async_rst_outputs", dut_vec(), 18'd0);
      #1 rst = 1'b0;
      cyc(0, 0, 0, OP_LD, 0, "ar_after");
`ifdef MULTICYCLE_CONTROL_PERF_EN
      // perf counters: R, store, branch after a fresh reset
      cyc(1, 1, 0, OP_R, 0, "pf_rst");
      cyc(0, 1, 0, OP_R, 0, "pf_r0");
      cyc(0, 1, 0, OP_R, 1, "pf_r1");
      cyc(0, 1, 0, OP_R, 5, "pf_r5");
      cyc(0, 1, 0, OP_R, 7, "pf_r7");
      cyc(0, 1, 0, OP_ST, 0, "pf_s0");
      cyc(0, 1, 0, OP_ST, 1, "pf_s1");
      cyc(0, 1, 0, OP_ST, 2, "pf_s2");
      cyc(0, 1, 0, OP_ST, 3, "pf_s3");
      cyc(0, 1, 0, OP_BR, 0, "pf_b0");
      cyc(0, 1, 0, OP_BR, 1, "pf_b1");
      cyc(0, 1, 0, OP_BR, 8, "pf_b8");
      cyc(0, 0, 0, OP_R, 0, "pf_done");
      #2;
      n_cmp++;
      if (instret_cnt !== 32'd3) begin
         n_err++;
         $display("FAIL instret_cnt: got %0d expected 3", instret_cnt);
      end
      n_cmp++;
      if (cycle_cnt !== 32'd11) begin
         n_err++;
         $display("FAIL cycle_cnt: got %0d expected 11", cycle_cnt);
      end
`endif
      @(negedge clk);
      #3;
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences a multicycle RV32I-subset datapath with one shared instruction/data memory port.
- Sits beside the register file, ALU, IR and PC registers. Drives their enables and mux selects each cycle.
- Handshakes with the memory port through req/ready.
- Opcode comes from the external IR and is valid from DECODE onward.

Parameters:
- OPC_W, 7, opcode width.
- ST_W, 4, width of the state_o debug output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0].
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_wr  out  1  PC register load enable.
- pc_src  out  1  PC source select: 0 = ALU result (PC+4), 1 = ALUOut register (branch target).
- ir_wr  out  1  IR load enable.
- mem_req  out  1  memory request.
- mem_wr  out  1  request is a write; valid only with mem_req.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_wr  out  1  register file write enable.
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = memory data register.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = decode by funct.
- illegal  out  1  unsupported opcode trap.
- state_o  out  ST_W  current state encoding, for debug.

Behaviour:
- Reset: asynchronous assertion of rst forces state to FETCH, including mid-operation. While rst is high, every output is 0 and state_o = 0.
- After rst deasserts, the first request is issued from FETCH. An in-flight memory access is abandoned on reset.
- All outputs are decoded from state only (Moore), except:
  - ir_wr/pc_wr in FETCH, which are qualified by mem_ready;
  - pc_wr in BRANCH, which is qualified by zero.
- Outputs not listed for a state are 0.
- FETCH (0):
  - mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - When mem_ready=1: ir_wr=1 and pc_wr=1 with pc_src=0, then go to DECODE. Otherwise stay.
- DECODE (1): alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - any other opcode -> TRAP
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_ACC.
- MEM_ACC (3):
  - mem_req=1, i_or_d=1, mem_wr=1 for a store.
  - Hold until mem_ready=1, then go to FETCH (store) or LOAD_WB (load).
- LOAD_WB (4): reg_wr=1, mem_to_reg=1. Go to FETCH.
- EXEC_R (5): alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB.
- EXEC_I (6): alu_src_a=1, alu_src_b=10, alu_op=10. Go to ALU_WB.
- ALU_WB (7): reg_wr=1, mem_to_reg=0. Go to FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_wr=zero. Go to FETCH.
- TRAP (9): illegal=1. Stays in TRAP until rst; no memory or register activity.
- Memory handshake:
  - mem_req, i_or_d and mem_wr stay stable until mem_ready is seen high.
  - mem_ready is ignored in all states except FETCH and MEM_ACC.
  - Zero-wait memory (mem_ready tied high) must work.
- Minimum cycles per instruction with zero-wait memory: R/I 4, load 5, store 4, branch 3.
- Unused state encodings (10–15) recover to FETCH on the next clock.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_PERF_EN.
- Defined: adds output ports cycle_cnt (32 bits) and instret_cnt (32 bits). Both reset to 0.
  - cycle_cnt increments every cycle while not in reset.
  - instret_cnt increments on every transition into FETCH from a completing state: LOAD_WB, ALU_WB, BRANCH, or a store MEM_ACC with mem_ready.
  - Both wrap modulo 2^32.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package multicycle_pkg holds:
  - opcode localparams LOAD, STORE, RTYPE, ITYPE, BEQ;
  - state_t enum with the explicit encodings above;
  - alu_op and alu_src_b encoding constants.
- Sub-module mc_opdec: combinational opcode classifier (is_mem, is_store, is_r, is_i, is_br, is_bad), used by DECODE and MEM_ACC.

Test Plan:
- Zero-wait R-type: reset, mem_ready=1, opcode=0110011 -> state_o sequence 0,1,5,7,0; reg_wr high only in state 7; ir_wr pulses once.
- Load with 2 wait cycles at MEM_ACC, opcode=0000011 -> mem_req=1 and i_or_d=1 held 3 cycles; then state 4 with reg_wr=1 and mem_to_reg=1; back to 0.
- Store, opcode=0100011 -> MEM_ACC with mem_wr=1, reg_wr never 1; returns to FETCH after ready; total 4 cycles.
- BEQ twice, zero=1 then zero=0 -> pc_wr=1 with pc_src=1 in state 8 on the first; pc_wr=0 in state 8 on the second.
- Opcode=1111111 -> TRAP, illegal=1 held for 20 cycles, mem_req=0. Asserting rst then returns to FETCH with illegal=0.
- rst asserted asynchronously mid-MEM_ACC (between clock edges) -> all outputs 0 immediately. With the macro defined: instret_cnt=3 after an R, store and branch sequence.
